wash_timer: RTL and testbench



---
 rtl/wash_pkg.sv | 60 ++++++
 rtl/wash_tick_gen.sv | 41 ++++
 rtl/wash_timer.sv | 119 +++++++++++
 tb/tb_wash_timer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared constants and stage-table helpers for the wash timer.
// State codes mirror the controller's 3-bit state encoding.
package wash_pkg;

   localparam logic [2:0] shutDownST = 3'd0;
   localparam logic [2:0] beginST    = 3'd1;
   localparam logic [2:0] setST      = 3'd2;
   localparam logic [2:0] runST      = 3'd3;
   localparam logic [2:0] errorST    = 3'd4;
   localparam logic [2:0] pauseST    = 3'd5;
   localparam logic [2:0] finishST   = 3'd6;
   localparam logic [2:0] sleepST    = 3'd7;

   localparam logic [3:0] STAGE_DUR [0:7] = '{4'd3, 4'd5, 4'd2, 4'd2,
                                              4'd3, 4'd5, 4'd2, 4'd2};

   localparam logic [5:0] SHOW_EMPTY = 6'd55;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } next_t;

   // Mask bit 7 is stage 0, so stage k lives at mask[7-k].
   function automatic logic stage_en(input logic [7:0] mask, input int k);
      return mask[3'(7 - k)];
   endfunction

   function automatic logic [2:0] first_stage(input logic [7:0] mask);
      logic [2:0] r;
      r = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (stage_en(mask, k)) r = 3'(k);
      end
      return r;
   endfunction

   function automatic next_t next_stage(input logic [7:0] mask, input logic [2:0] cur);
      next_t r;
      r.found = 1'b0;
      r.idx   = cur;
      for (int k = 7; k >= 0; k--) begin
         if (k > int'(cur) && stage_en(mask, k)) begin
            r.found = 1'b1;
            r.idx   = 3'(k);
         end
      end
      return r;
   endfunction

   function automatic logic [4:0] total_dur(input logic [7:0] mask);
      logic [4:0] s;
      s = 5'd0;
      for (int k = 0; k < 8; k++) begin
         if (stage_en(mask, k)) s = s + 5'(STAGE_DUR[k]);
      end
      return s;
   endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// Prescaler producing the 1 Hz 50%-duty `second` wave and a one-cycle
// tick on the cycle the prescaler wraps.
module wash_tick_gen #(
   parameter int CLK_HZ = 1000
) (
   input  logic cp,
   input  logic reset,
   output logic second_o,
   output logic tick_o
);

   localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);

   if (CLK_HZ < 2 || (CLK_HZ % 2) != 0) begin : g_bad_clk_hz
      $error("wash_tick_gen: CLK_HZ must be even and at least 2");
   end

   logic [PW-1:0] presc_q, presc_d;
   logic          second_q;

   always_comb begin
      presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
   end

   // second_q tracks (presc_q >= HALF) without a combinational output path.
   always_ff @(posedge cp) begin
      if (reset) begin
         presc_q  <= '0;
         second_q <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         second_q <= (presc_d >= HALF);
      end
   end

   assign tick_o   = (presc_q == LAST);
   assign second_o = second_q;

endmodule

// File: rtl/wash_timer.sv
// Wash stage sequencer: counts down per-stage and total seconds and drives
// the view-stage digit codes. WASH_TIMER_BLANK_EN blanks inLeft below 10 s.
//
// state | meaning
// 0,1,2,6,7 | load: point at first enabled stage, preset counters
// 3         | run: count down on each tick, advance through stages
// 4,5       | error/pause: counters and stage index frozen
module wash_timer
   import wash_pkg::*;
#(
   parameter int CLK_HZ = 1000
) (
   input  logic       cp,
   input  logic       reset,
   input  logic [2:0] state,
   input  logic [7:0] stageMask,
   output logic       second,
   output logic [2:0] shinning,
   output logic [5:0] inLeft,
   output logic [5:0] inMiddle,
   output logic [5:0] inRight,
   output logic       stageDone,
   output logic       allDone
);

   logic       tick;
   logic [2:0] shin_q;
   logic [3:0] srem_q;
   logic [4:0] trem_q;
   logic       done_q;
   logic       sdone_q, adone_q;
   logic [5:0] left_q, mid_q, right_q;
   logic [5:0] left_d, mid_d, right_d;

   logic       load_st;
   logic [2:0] first_idx;
   logic [3:0] first_dur;
   logic [4:0] sum_dur;
   next_t      nxt;

   wash_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
      .cp       (cp),
      .reset    (reset),
      .second_o (second),
      .tick_o   (tick)
   );

   always_comb begin
      load_st   = (state == shutDownST) || (state == beginST) || (state == setST) ||
                  (state == finishST)   || (state == sleepST);
      first_idx = first_stage(stageMask);
      first_dur = (stageMask == 8'd0) ? 4'd0 : STAGE_DUR[first_idx];
      sum_dur   = total_dur(stageMask);
      nxt       = next_stage(stageMask, shin_q);
   end

   always_comb begin
      left_d  = 6'(trem_q / 5'd10);
      mid_d   = 6'(trem_q % 5'd10);
      right_d = {2'b00, srem_q};
`ifdef WASH_TIMER_BLANK_EN
      if (trem_q < 5'd10) left_d = SHOW_EMPTY;
`endif
   end

   always_ff @(posedge cp) begin
      if (reset) begin
         shin_q  <= 3'd0;
         srem_q  <= 4'd0;
         trem_q  <= 5'd0;
         done_q  <= 1'b0;
         sdone_q <= 1'b0;
         adone_q <= 1'b0;
         left_q  <= 6'd0;
         mid_q   <= 6'd0;
         right_q <= 6'd0;
      end else begin
         sdone_q <= 1'b0;
         adone_q <= 1'b0;
         left_q  <= left_d;
         mid_q   <= mid_d;
         right_q <= right_d;
         if (load_st) begin
            shin_q <= first_idx;
            srem_q <= first_dur;
            trem_q <= sum_dur;
            done_q <= 1'b0;
         end else if (state == runST && tick) begin
            if (srem_q > 4'd1) begin
               srem_q <= srem_q - 4'd1;
               trem_q <= trem_q - 5'd1;
            end else if (srem_q == 4'd1) begin
               trem_q  <= trem_q - 5'd1;
               sdone_q <= 1'b1;
               if (nxt.found) begin
                  shin_q <= nxt.idx;
                  srem_q <= STAGE_DUR[nxt.idx];
               end else begin
                  adone_q <= 1'b1;
                  srem_q  <= 4'd0;
                  done_q  <= 1'b1;
               end
            end else if (!done_q) begin
               // Empty mask: announce completion once per run.
               adone_q <= 1'b1;
               done_q  <= 1'b1;
            end
         end
      end
   end

   assign shinning  = shin_q;
   assign inLeft    = left_q;
   assign inMiddle  = mid_q;
   assign inRight   = right_q;
   assign stageDone = sdone_q;
   assign allDone   = adone_q;

endmodule

// File: tb/tb_wash_timer.sv
// Self-checking bench for wash_timer at CLK_HZ=4 with a per-cycle
// stage-list model and directed literal checkpoints.
module tb_wash_timer;

   localparam int CLK_HZ = 4;

   logic       cp = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] state = 3'd0;
   logic [7:0] stageMask = 8'hFF;
   logic       second;
   logic [2:0] shinning;
   logic [5:0] inLeft, inMiddle, inRight;
   logic       stageDone, allDone;

   wash_timer #(.CLK_HZ(CLK_HZ)) dut (
      .cp        (cp),
      .reset     (reset),
      .state     (state),
      .stageMask (stageMask),
      .second    (second),
      .shinning  (shinning),
      .inLeft    (inLeft),
      .inMiddle  (inMiddle),
      .inRight   (inRight),
      .stageDone (stageDone),
      .allDone   (allDone)
   );

   initial forever #5 cp = ~cp;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int n_tests = 0;
   int n_fail  = 0;

   int dur [8] = '{3, 5, 2, 2, 3, 5, 2, 2};
   int m_list [8];
   int m_n = 0, m_pos = 0, m_cyc = 0, m_ticks = 0;
   int m_srem = 0, m_trem = 0, m_shin = 0, m_done = 0;
   int e_sdone = 0, e_adone = 0, e_left = 0, e_mid = 0, e_right = 0;
   int cnt_sdone = 0, cnt_adone = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int left_code(input int t);
`ifdef WASH_TIMER_BLANK_EN
      if (t < 10) return 55;
`endif
      return t / 10;
   endfunction

   // Advance the model by one clock edge using the inputs the DUT samples.
   task automatic model_edge();
      bit tk;
      if (reset) begin
         m_cyc = 0; m_srem = 0; m_trem = 0; m_shin = 0; m_done = 0;
         m_n = 0; m_pos = 0;
         e_sdone = 0; e_adone = 0; e_left = 0; e_mid = 0; e_right = 0;
         return;
      end
      e_left  = left_code(m_trem);
      e_mid   = m_trem % 10;
      e_right = m_srem;
      tk = ((m_cyc % CLK_HZ) == CLK_HZ - 1);
      m_cyc++;
      if (tk) m_ticks++;
      e_sdone = 0;
      e_adone = 0;
      if (state inside {3'd0, 3'd1, 3'd2, 3'd6, 3'd7}) begin
         m_n = 0; m_trem = 0; m_pos = 0; m_done = 0;
         for (int k = 0; k < 8; k++) begin
            if (stageMask[3'(7 - k)]) begin
               m_list[m_n] = k;
               m_n++;
               m_trem += dur[k];
            end
         end
         m_shin = (m_n > 0) ? m_list[0] : 0;
         m_srem = (m_n > 0) ? dur[m_list[0]] : 0;
      end else if (state == 3'd3 && tk) begin
         if (m_srem > 1) begin
            m_srem--; m_trem--;
         end else if (m_srem == 1) begin
            m_trem--;
            e_sdone = 1;
            if (m_pos + 1 < m_n) begin
               m_pos++;
               m_shin = m_list[m_pos];
               m_srem = dur[m_shin];
            end else begin
               e_adone = 1; m_srem = 0; m_done = 1;
            end
         end else if (m_done == 0) begin
            e_adone = 1; m_done = 1;
         end
      end
   endtask

   task automatic compare_all();
      check("second",    second,    ((m_cyc % CLK_HZ) >= CLK_HZ / 2));
      check("shinning",  shinning,  m_shin);
      check("inLeft",    inLeft,    e_left);
      check("inMiddle",  inMiddle,  e_mid);
      check("inRight",   inRight,   e_right);
      check("stageDone", stageDone, e_sdone);
      check("allDone",   allDone,   e_adone);
      if (stageDone === 1'b1) cnt_sdone++;
      if (allDone === 1'b1)   cnt_adone++;
   endtask

   task automatic step();
      @(posedge cp);
      model_edge();
      @(negedge cp);
      compare_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_ticks(input int n);
      int target, budget;
      target = m_ticks + n;
      budget = 0;
      while (m_ticks < target && budget < 50 * CLK_HZ) begin
         step();
         budget++;
      end
      n_tests++;
      if (m_ticks < target) begin
         n_fail++;
         $display("FAIL wait_ticks: got %0d ticks, expected %0d", m_ticks, target);
      end
   endtask

   initial begin
      int tog, sd0, ad0;
      logic prev;

      reset = 1'b1; state = 3'd0; stageMask = 8'hFF;
      steps(3);
      check("rst_shinning", shinning, 0);
      check("rst_inLeft",   inLeft,   0);
      check("rst_inRight",  inRight,  0);
      check("rst_second",   second,   0);
      check("rst_allDone",  allDone,  0);

      reset = 1'b0;
      steps(20);
      check("load_shinning", shinning, 0);
      check("load_inLeft",   inLeft,   2);
      check("load_inMiddle", inMiddle, 4);
      check("load_inRight",  inRight,  3);
      check("model_total24", m_trem,   24);
      tog = 0;
      prev = second;
      for (int i = 0; i < 8; i++) begin
         step();
         if (second !== prev) tog++;
         prev = second;
      end
      check("second_toggles", tog, 4);

      // Full mask: first stage ends after its third tick.
      state = 3'd3;
      sd0 = cnt_sdone;
      wait_ticks(3);
      steps(2);
      check("s0_done_count", cnt_sdone - sd0, 1);
      check("s0_shinning",   shinning, 1);
      check("s0_inRight",    inRight,  5);
      check("s0_inLeft",     inLeft,   2);
      check("s0_inMiddle",   inMiddle, 1);

      // Stages 0 and 7 only.
      state = 3'd0; stageMask = 8'b1000_0001;
      steps(3);
      check("m81_inMiddle", inMiddle, 5);
      check("m81_inRight",  inRight,  3);
      state = 3'd3;
      ad0 = cnt_adone;
      wait_ticks(3);
      steps(2);
      check("m81_shin7", shinning, 7);
      check("m81_right2", inRight, 2);
      wait_ticks(6);
      steps(2);
      check("m81_alldone_once", cnt_adone - ad0, 1);
      check("m81_end_shin",   shinning, 7);
      check("m81_end_left",   inLeft,   left_code(0));
      check("m81_end_middle", inMiddle, 0);
      check("m81_end_right",  inRight,  0);

      // Pause holds the countdown mid-stage.
      state = 3'd0; stageMask = 8'hFF;
      steps(3);
      state = 3'd3;
      wait_ticks(2);
      steps(2);
      check("pre_pause_right", inRight,  1);
      check("pre_pause_mid",   inMiddle, 2);
      state = 3'd5;
      sd0 = cnt_sdone;
      steps(12);
      check("pause_right",  inRight,  1);
      check("pause_left",   inLeft,   2);
      check("pause_mid",    inMiddle, 2);
      check("pause_nodone", cnt_sdone - sd0, 0);
      state = 3'd3;
      wait_ticks(1);
      steps(2);
      check("resume_done", cnt_sdone - sd0, 1);
      check("resume_shin", shinning, 1);
      check("resume_right", inRight, 5);
      check("resume_mid",  inMiddle, 1);

      // Empty mask.
      state = 3'd0; stageMask = 8'h00;
      steps(3);
      check("empty_right", inRight,  0);
      check("empty_mid",   inMiddle, 0);
      state = 3'd3;
      ad0 = cnt_adone; sd0 = cnt_sdone;
      wait_ticks(4);
      steps(2);
      check("empty_alldone_once", cnt_adone - ad0, 1);
      check("empty_no_stagedone", cnt_sdone - sd0, 0);
      check("empty_left", inLeft, left_code(0));

      // Reset mid-run.
      state = 3'd0; stageMask = 8'hFF;
      steps(3);
      state = 3'd3;
      wait_ticks(2);
      steps(1);
      reset = 1'b1;
      step();
      check("mrst_shin",   shinning, 0);
      check("mrst_left",   inLeft,   0);
      check("mrst_mid",    inMiddle, 0);
      check("mrst_right",  inRight,  0);
      check("mrst_second", second,   0);
      check("mrst_sdone",  stageDone, 0);
      reset = 1'b0; state = 3'd0; stageMask = 8'hB0;
      steps(3);
      check("model_total7", m_trem, 7);
      check("t7_mid", inMiddle, 7);
`ifdef WASH_TIMER_BLANK_EN
      check("t7_left_blank", inLeft, 55);
`else
      check("t7_left_zero", inLeft, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
